data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, meaning wait states between request acceptance and response (range 0-15).
REQ-002 Parameter DEPTH_WORDS, default 32, meaning number of 32-bit storage words.
REQ-003 clk  input  1  clock; all state changes on posedge clk.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder accepts a request this cycle.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-010 req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend; ignored for word accesses and stores.
REQ-011 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 resp_valid  output  1  response available.
REQ-013 resp_ready  input  1  initiator accepts the response.
REQ-014 resp_rdata  output  32  load data, extended per REQ-010; 0 for stores and errors.
REQ-015 resp_err  output  1  1 = access rejected.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE; resp_valid SHALL be 1 only in RESP.
REQ-017 The request handshake (req_valid & req_ready at a posedge) SHALL capture write, addr, size, unsigned and wdata into internal registers; inputs are don't-care after that edge.
REQ-018 From IDLE on handshake: WAIT_CYCLES=0 -> RESP; otherwise -> WAIT with counter loaded to WAIT_CYCLES-1.
REQ-019 In WAIT: counter decrements each cycle; counter==0 -> RESP at the next edge; resp_valid asserts exactly WAIT_CYCLES+1 cycles after the accepting edge.
REQ-020 In RESP, resp_rdata and resp_err SHALL hold stable until resp_valid & resp_ready at a posedge, then -> IDLE; no request is accepted on the edge that completes a response (one idle cycle minimum between transactions).
REQ-021 The error condition SHALL be: size=11; halfword with addr[0]=1; word with addr[1:0]!=00; or word index addr[31:2] >= DEPTH_WORDS.
REQ-022 On error: no storage change; resp_err=1; resp_rdata=0.
REQ-023 Store write SHALL occur on the edge entering RESP; byte store updates lane addr[1:0], halfword store updates lane addr[1] (bits [15:0] or [31:16]); other bytes preserved.
REQ-024 Load data SHALL be read on the edge entering RESP, selected by lane, and extended to 32 bits; a load never modifies storage.
REQ-025 Store response SHALL be resp_err=0, resp_rdata=0.
REQ-026 Storage and internal registers SHALL be fully synchronous; no combinational path from req_* to resp_*.

Reset
REQ-027 While reset=1 at a posedge: state IDLE, counter 0, resp_valid=0, resp_err=0, resp_rdata=0, all storage words 0; req_ready=1 after the reset edge.
REQ-028 Reset in WAIT or RESP SHALL abandon the transaction without performing its store and without emitting a response.
REQ-029 A req_valid asserted during the reset cycle SHALL NOT be accepted.

Verification
REQ-030 Store word 0xDEADBEEF to addr 0x08, then load word from 0x08 with WAIT_CYCLES=2 -> resp_valid rises 3 cycles after acceptance, resp_rdata=0xDEADBEEF, resp_err=0.
REQ-031 After REQ-030: byte store 0x11 at 0x09, then signed byte load at 0x0B -> 0xFFFFFFDE; unsigned halfword load at 0x08 -> 0x000011EF.
REQ-032 Halfword load at 0x03, word load at 0x06, size=11, and word load at 0x80 (DEPTH_WORDS=32) -> resp_err=1, resp_rdata=0, storage unchanged.
REQ-033 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid, resp_rdata, resp_err stable; req_ready=0 throughout; response completes on the first resp_ready=1 edge.
REQ-034 Word store 0x12345678 at 0x10, reset asserted one cycle after acceptance (in WAIT) -> no response, load from 0x10 after reset returns 0.
REQ-035 WAIT_CYCLES=0 build: back-to-back requests with resp_ready=1 -> each response exactly 1 cycle after acceptance, one transaction per 2 cycles.

Source files
------------

// File: rtl/data_mem_responder.sv
// Single-port data memory responder with a valid/ready request channel,
// a fixed number of wait states, sub-word loads/stores and error reporting.
module data_mem_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH_WORDS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int         IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_LOAD   = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [29:0] DEPTH_LIMIT = 30'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state;
  state_t state_next;

  logic [3:0]  count;
  logic        cap_write;
  logic        cap_unsigned;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [1:0]  cap_size;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        enter_resp;
  logic        complete;

  logic        acc_write;
  logic        acc_unsigned;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [1:0]  acc_size;
  logic        acc_err;
  logic [IDX_W-1:0] acc_idx;
  logic [31:0] cur_word;
  logic [31:0] store_word;
  logic [31:0] load_data;
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  // Handshake-level outputs are pure functions of the state.
  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);

  // State register; reset abandons whatever transaction is in flight.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic plus the one-cycle event strobes that drive the datapath.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    enter_resp = 1'b0;
    complete   = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_next = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (count == 4'd0) begin
          state_next = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_next = S_IDLE;
          complete   = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Capture the request on acceptance and run the wait-state counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      count        <= 4'd0;
      cap_write    <= 1'b0;
      cap_unsigned <= 1'b0;
      cap_addr     <= 32'd0;
      cap_wdata    <= 32'd0;
      cap_size     <= 2'b00;
    end else if (accept) begin
      count        <= WAIT_LOAD;
      cap_write    <= req_write;
      cap_unsigned <= req_unsigned;
      cap_addr     <= req_addr;
      cap_wdata    <= req_wdata;
      cap_size     <= req_size;
    end else if (state == S_WAIT && count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  // With zero wait states the access completes on the accepting edge, so the
  // live request is used in IDLE and the captured copy everywhere else.
  always_comb begin
    if (state == S_IDLE) begin
      acc_write    = req_write;
      acc_unsigned = req_unsigned;
      acc_addr     = req_addr;
      acc_wdata    = req_wdata;
      acc_size     = req_size;
    end else begin
      acc_write    = cap_write;
      acc_unsigned = cap_unsigned;
      acc_addr     = cap_addr;
      acc_wdata    = cap_wdata;
      acc_size     = cap_size;
    end
  end

  assign acc_idx = acc_addr[IDX_W+1:2];

  // Reject illegal sizes, misaligned accesses and addresses past the storage.
  always_comb begin
    acc_err = 1'b0;
    case (acc_size)
      2'b00:   acc_err = 1'b0;
      2'b01:   acc_err = acc_addr[0];
      2'b10:   acc_err = (acc_addr[1:0] != 2'b00);
      default: acc_err = 1'b1;
    endcase
    if (acc_addr[31:2] >= DEPTH_LIMIT) acc_err = 1'b1;
  end

  // Lane selection for loads and read-modify-write merge for stores.
  always_comb begin
    cur_word = mem[acc_idx];
    case (acc_addr[1:0])
      2'b00:   load_byte = cur_word[7:0];
      2'b01:   load_byte = cur_word[15:8];
      2'b10:   load_byte = cur_word[23:16];
      default: load_byte = cur_word[31:24];
    endcase
    load_half = acc_addr[1] ? cur_word[31:16] : cur_word[15:0];
    case (acc_size)
      2'b00:   load_data = acc_unsigned ? {24'd0, load_byte} : {{24{load_byte[7]}}, load_byte};
      2'b01:   load_data = acc_unsigned ? {16'd0, load_half} : {{16{load_half[15]}}, load_half};
      default: load_data = cur_word;
    endcase
    store_word = cur_word;
    case (acc_size)
      2'b00: begin
        case (acc_addr[1:0])
          2'b00:   store_word[7:0]   = acc_wdata[7:0];
          2'b01:   store_word[15:8]  = acc_wdata[7:0];
          2'b10:   store_word[23:16] = acc_wdata[7:0];
          default: store_word[31:24] = acc_wdata[7:0];
        endcase
      end
      2'b01: begin
        if (acc_addr[1]) store_word[31:16] = acc_wdata[15:0];
        else             store_word[15:0]  = acc_wdata[15:0];
      end
      default: store_word = acc_wdata;
    endcase
  end

  // Response registers load on the edge entering RESP and hold until completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else if (enter_resp) begin
      resp_err   <= acc_err;
      resp_rdata <= (acc_err || acc_write) ? 32'd0 : load_data;
    end else if (complete) begin
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end
  end

  // Storage: cleared by reset, written only by a legal store entering RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'd0;
    end else if (enter_resp && acc_write && !acc_err) begin
      mem[acc_idx] <= store_word;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with two wait states,
// one with zero wait states for the back-to-back throughput case.
module tb_data_mem_responder;

  logic        clk;
  logic        reset;

  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  logic        b2b_req_valid, b2b_req_ready, b2b_req_write, b2b_req_unsigned;
  logic [31:0] b2b_req_addr, b2b_req_wdata;
  logic [1:0]  b2b_req_size;
  logic        b2b_resp_valid, b2b_resp_ready, b2b_resp_err;
  logic [31:0] b2b_resp_rdata;

  int tests_run;
  int tests_failed;

  typedef struct packed {
    logic        w;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        er;
  } vec_t;

  data_mem_responder #(.WAIT_CYCLES(2), .DEPTH_WORDS(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err)
  );

  data_mem_responder #(.WAIT_CYCLES(0), .DEPTH_WORDS(32)) dut_b2b (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (b2b_req_valid),
    .req_ready    (b2b_req_ready),
    .req_write    (b2b_req_write),
    .req_addr     (b2b_req_addr),
    .req_size     (b2b_req_size),
    .req_unsigned (b2b_req_unsigned),
    .req_wdata    (b2b_req_wdata),
    .resp_valid   (b2b_resp_valid),
    .resp_ready   (b2b_resp_ready),
    .resp_rdata   (b2b_resp_rdata),
    .resp_err     (b2b_resp_err)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One full transaction on the main instance. lat is the 1-based cycle after
  // the accepting edge in which resp_valid is first seen; fields are scrambled
  // right after acceptance to show they are captured.
  task automatic txn(input logic w, input logic [31:0] addr, input logic [1:0] size,
                     input logic uns, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er, output int lat);
    int guard;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wd;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    req_valid = 1'b0; req_write = ~w; req_addr = 32'hFFFF_FFFF;
    req_size = 2'b11; req_unsigned = ~uns; req_wdata = 32'hA5A5_A5A5;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = resp_rdata;
    er = resp_err;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0; req_size = 2'b10;
    req_unsigned = 1'b0; req_wdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({resp_valid, resp_err, resp_rdata} !== 34'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got valid=%0b err=%0b rdata=%h, expected 0/0/00000000",
               resp_valid, resp_err, resp_rdata);
    end
    reset = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({req_ready, resp_valid} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL reset_idle: got req_ready=%0b resp_valid=%0b, expected 1/0",
               req_ready, resp_valid);
    end
  endtask

  task automatic test_word_rw();
    vec_t v [3];
    logic [31:0] rd;
    logic er;
    int lat;
    v[0] = '{1'b1, 32'h08, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h0,         1'b0};
    v[1] = '{1'b0, 32'h08, 2'b10, 1'b0, 32'h0,         32'hDEAD_BEEF, 1'b0};
    v[2] = '{1'b0, 32'h00, 2'b10, 1'b0, 32'h0,         32'h0,         1'b0};
    foreach (v[i]) begin
      txn(v[i].w, v[i].addr, v[i].size, v[i].uns, v[i].wd, rd, er, lat);
      tests_run++;
      if ({er, rd} !== {v[i].er, v[i].rd}) begin
        tests_failed++;
        $display("[TB] FAIL word_rw[%0d] resp: got err=%0b rdata=%h, expected err=%0b rdata=%h",
                 i, er, rd, v[i].er, v[i].rd);
      end
      tests_run++;
      if (lat != 3) begin
        tests_failed++;
        $display("[TB] FAIL word_rw[%0d] latency: got %0d, expected 3", i, lat);
      end
    end
  endtask

  task automatic test_byte_half();
    vec_t v [11];
    logic [31:0] rd;
    logic er;
    int lat;
    v[0]  = '{1'b1, 32'h09, 2'b00, 1'b0, 32'hCCCC_CC11, 32'h0,         1'b0};
    v[1]  = '{1'b0, 32'h0B, 2'b00, 1'b0, 32'h0,         32'hFFFF_FFDE, 1'b0};
    v[2]  = '{1'b0, 32'h08, 2'b01, 1'b1, 32'h0,         32'h0000_11EF, 1'b0};
    v[3]  = '{1'b0, 32'h0A, 2'b01, 1'b0, 32'h0,         32'hFFFF_DEAD, 1'b0};
    v[4]  = '{1'b0, 32'h09, 2'b00, 1'b1, 32'h0,         32'h0000_0011, 1'b0};
    v[5]  = '{1'b1, 32'h0E, 2'b01, 1'b0, 32'h7777_8001, 32'h0,         1'b0};
    v[6]  = '{1'b0, 32'h0C, 2'b10, 1'b0, 32'h0,         32'h8001_0000, 1'b0};
    v[7]  = '{1'b0, 32'h0E, 2'b01, 1'b0, 32'h0,         32'hFFFF_8001, 1'b0};
    v[8]  = '{1'b1, 32'h0C, 2'b00, 1'b0, 32'h0000_00AB, 32'h0,         1'b0};
    v[9]  = '{1'b0, 32'h0C, 2'b00, 1'b0, 32'h0,         32'hFFFF_FFAB, 1'b0};
    v[10] = '{1'b0, 32'h08, 2'b10, 1'b1, 32'h0,         32'hDEAD_11EF, 1'b0};
    foreach (v[i]) begin
      txn(v[i].w, v[i].addr, v[i].size, v[i].uns, v[i].wd, rd, er, lat);
      tests_run++;
      if ({er, rd} !== {v[i].er, v[i].rd}) begin
        tests_failed++;
        $display("[TB] FAIL byte_half[%0d] resp: got err=%0b rdata=%h, expected err=%0b rdata=%h",
                 i, er, rd, v[i].er, v[i].rd);
      end
    end
  endtask

  task automatic test_errors();
    vec_t v [11];
    logic [31:0] rd;
    logic er;
    int lat;
    v[0]  = '{1'b0, 32'h03, 2'b01, 1'b0, 32'h0,         32'h0,         1'b1};
    v[1]  = '{1'b0, 32'h06, 2'b10, 1'b0, 32'h0,         32'h0,         1'b1};
    v[2]  = '{1'b0, 32'h08, 2'b11, 1'b0, 32'h0,         32'h0,         1'b1};
    v[3]  = '{1'b0, 32'h80, 2'b10, 1'b0, 32'h0,         32'h0,         1'b1};
    v[4]  = '{1'b1, 32'h06, 2'b10, 1'b0, 32'hFFFF_FFFF, 32'h0,         1'b1};
    v[5]  = '{1'b1, 32'h80, 2'b10, 1'b0, 32'hFFFF_FFFF, 32'h0,         1'b1};
    v[6]  = '{1'b0, 32'h04, 2'b10, 1'b0, 32'h0,         32'h0,         1'b0};
    v[7]  = '{1'b0, 32'h00, 2'b10, 1'b0, 32'h0,         32'h0,         1'b0};
    v[8]  = '{1'b0, 32'h08, 2'b10, 1'b0, 32'h0,         32'hDEAD_11EF, 1'b0};
    v[9]  = '{1'b1, 32'h7C, 2'b10, 1'b0, 32'h0BAD_F00D, 32'h0,         1'b0};
    v[10] = '{1'b0, 32'h7C, 2'b10, 1'b0, 32'h0,         32'h0BAD_F00D, 1'b0};
    foreach (v[i]) begin
      txn(v[i].w, v[i].addr, v[i].size, v[i].uns, v[i].wd, rd, er, lat);
      tests_run++;
      if ({er, rd} !== {v[i].er, v[i].rd}) begin
        tests_failed++;
        $display("[TB] FAIL errors[%0d] resp: got err=%0b rdata=%h, expected err=%0b rdata=%h",
                 i, er, rd, v[i].er, v[i].rd);
      end
      tests_run++;
      if (lat != 3) begin
        tests_failed++;
        $display("[TB] FAIL errors[%0d] latency: got %0d, expected 3", i, lat);
      end
    end
  endtask

  task automatic test_hold();
    int guard;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h08; req_size = 2'b10; req_unsigned = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    guard = 0;
    while (!resp_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    for (int k = 0; k < 5; k++) begin
      tests_run++;
      if ({resp_valid, resp_err, req_ready, resp_rdata} !== {3'b100, 32'hDEAD_11EF}) begin
        tests_failed++;
        $display("[TB] FAIL hold[%0d]: got valid=%0b err=%0b req_ready=%0b rdata=%h, expected 1/0/0/dead11ef",
                 k, resp_valid, resp_err, req_ready, resp_rdata);
      end
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    tests_run++;
    if ({resp_valid, req_ready} !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL hold_release: got valid=%0b req_ready=%0b, expected 0/1",
               resp_valid, req_ready);
    end
  endtask

  task automatic test_back_to_back();
    vec_t v [5];
    v[0] = '{1'b1, 32'h00, 2'b10, 1'b0, 32'hCAFE_F00D, 32'h0,         1'b0};
    v[1] = '{1'b0, 32'h00, 2'b10, 1'b0, 32'h0,         32'hCAFE_F00D, 1'b0};
    v[2] = '{1'b0, 32'h03, 2'b00, 1'b0, 32'h0,         32'hFFFF_FFCA, 1'b0};
    v[3] = '{1'b0, 32'h02, 2'b01, 1'b1, 32'h0,         32'h0000_CAFE, 1'b0};
    v[4] = '{1'b0, 32'h02, 2'b10, 1'b0, 32'h0,         32'h0,         1'b1};
    @(negedge clk);
    b2b_resp_ready = 1'b1;
    foreach (v[i]) begin
      b2b_req_valid = 1'b1; b2b_req_write = v[i].w; b2b_req_addr = v[i].addr;
      b2b_req_size = v[i].size; b2b_req_unsigned = v[i].uns; b2b_req_wdata = v[i].wd;
      tests_run++;
      if ({b2b_req_ready, b2b_resp_valid} !== 2'b10) begin
        tests_failed++;
        $display("[TB] FAIL b2b[%0d] idle: got req_ready=%0b resp_valid=%0b, expected 1/0",
                 i, b2b_req_ready, b2b_resp_valid);
      end
      @(negedge clk);
      tests_run++;
      if ({b2b_resp_valid, b2b_req_ready, b2b_resp_err, b2b_resp_rdata} !== {2'b10, v[i].er, v[i].rd}) begin
        tests_failed++;
        $display("[TB] FAIL b2b[%0d] resp: got valid=%0b req_ready=%0b err=%0b rdata=%h, expected 1/0/%0b/%h",
                 i, b2b_resp_valid, b2b_req_ready, b2b_resp_err, b2b_resp_rdata, v[i].er, v[i].rd);
      end
      @(negedge clk);
    end
    b2b_req_valid = 1'b0;
    b2b_resp_ready = 1'b0;
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd;
    logic er;
    int lat;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_size = 2'b10;
    req_unsigned = 1'b0; req_wdata = 32'h1234_5678;
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (resp_valid !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL abort_no_resp[%0d]: got resp_valid=%0b, expected 0", k, resp_valid);
      end
      @(negedge clk);
    end
    txn(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, rd, er, lat);
    tests_run++;
    if ({er, rd} !== 33'd0 || lat != 3) begin
      tests_failed++;
      $display("[TB] FAIL abort_load: got err=%0b rdata=%h lat=%0d, expected 0/00000000/3",
               er, rd, lat);
    end
  endtask

  // Run the scenarios in order, then report.
  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_size = 2'b00;
    req_unsigned = 1'b0; req_wdata = 32'h0; resp_ready = 1'b0;
    b2b_req_valid = 1'b0; b2b_req_write = 1'b0; b2b_req_addr = 32'h0; b2b_req_size = 2'b00;
    b2b_req_unsigned = 1'b0; b2b_req_wdata = 32'h0; b2b_resp_ready = 1'b0;
    test_reset();
    test_word_rw();
    test_byte_half();
    test_errors();
    test_hold();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
